// File: rtl/fpdsp_issue_ctrl.sv
// fpdsp_issue_ctrl: command buffer and single-outstanding issue controller for
// the iterative FP DSP unit. Commands {A, B, op, tag} are queued in a small
// FIFO. They are issued one at a time over the run/ready handshake, and each
// captured result comes back tagged on a valid/ready response stream.
// Optional feature macro: FPDSP_ISSUE_TIMEOUT_EN. It adds an issue-to-completion
// watchdog that returns a quiet-NaN "invalid" response, and a DRAIN state that
// waits out the stuck operation before the next issue.
module fpdsp_issue_ctrl #(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             dsp_run,
    output logic [31:0]      dsp_a,
    output logic [31:0]      dsp_b,
    output logic [1:0]       dsp_operation,
    input  logic [31:0]      dsp_result,
    input  logic [4:0]       dsp_flags,
    input  logic             dsp_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 32 + 32 + 2 + TAG_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
`ifdef FPDSP_ISSUE_TIMEOUT_EN
        S_HOLD,
        S_DRAIN
`else
        S_HOLD
`endif
    } state_t;

    state_t             state_reg;
    logic [ENT_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic               wb_cnt_reg;
    logic               push;
    logic               issue_go;
    logic               done_hit;

    assign cmd_ready = (count_reg != CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // The FIFO pops on the same edge that moves IDLE -> ISSUE.
    assign issue_go  = (state_reg == S_IDLE) && (count_reg != '0) && dsp_ready;
    // Completion: ready seen in WAIT_DONE, or ready never dropped after two WAIT_BUSY cycles.
    assign done_hit  = dsp_ready && ((state_reg == S_WAIT_DONE) ||
                                     ((state_reg == S_WAIT_BUSY) && wb_cnt_reg));
    assign busy      = (state_reg != S_IDLE) || (count_reg != '0);

`ifdef FPDSP_ISSUE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            to_hit;
    assign to_hit = (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
`else
    assign rsp_timeout = 1'b0;
`endif

    // Command storage: plain array without reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (issue_go) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !issue_go) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!push && issue_go) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Issue FSM with registered FP DSP and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            dsp_run       <= 1'b0;
            dsp_a         <= '0;
            dsp_b         <= '0;
            dsp_operation <= '0;
            tag_reg       <= '0;
            wb_cnt_reg    <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_flags     <= '0;
            rsp_tag       <= '0;
`ifdef FPDSP_ISSUE_TIMEOUT_EN
            rsp_timeout   <= 1'b0;
            to_cnt_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (issue_go) begin
                        {dsp_a, dsp_b, dsp_operation, tag_reg} <= fifo_mem[rd_ptr_reg];
                        dsp_run   <= 1'b1;
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    dsp_run    <= 1'b0;
                    wb_cnt_reg <= 1'b0;
`ifdef FPDSP_ISSUE_TIMEOUT_EN
                    to_cnt_reg <= '0;
`endif
                    state_reg  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (done_hit) begin
                        rsp_result  <= dsp_result;
                        rsp_flags   <= dsp_flags;
                        rsp_tag     <= tag_reg;
                        rsp_valid   <= 1'b1;
`ifdef FPDSP_ISSUE_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
`endif
                        state_reg   <= S_HOLD;
`ifdef FPDSP_ISSUE_TIMEOUT_EN
                    end else if (to_hit) begin
                        rsp_result  <= 32'h7FC0_0000;
                        rsp_flags   <= 5'b10000;
                        rsp_tag     <= tag_reg;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state_reg   <= S_HOLD;
`endif
                    end else begin
                        if (state_reg == S_WAIT_BUSY) begin
                            if (!dsp_ready) begin
                                state_reg <= S_WAIT_DONE;
                            end else begin
                                wb_cnt_reg <= 1'b1;
                            end
                        end
`ifdef FPDSP_ISSUE_TIMEOUT_EN
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
`endif
                    end
                end
                S_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifdef FPDSP_ISSUE_TIMEOUT_EN
                        state_reg <= rsp_timeout ? S_DRAIN : S_IDLE;
`else
                        state_reg <= S_IDLE;
`endif
                    end
                end
`ifdef FPDSP_ISSUE_TIMEOUT_EN
                S_DRAIN: begin
                    if (dsp_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
`endif
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpdsp_issue_ctrl.sv
// tb_fpdsp_issue_ctrl: directed bench for fpdsp_issue_ctrl. It contains a
// behavioural FP DSP model with per-command fall/latency, a scoreboard queue of
// expected responses, and a monitor that pops and compares on each response
// handshake.
module tb_fpdsp_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_tag = '0;
    logic        dsp_run;
    logic [31:0] dsp_a;
    logic [31:0] dsp_b;
    logic [1:0]  dsp_operation;
    logic [31:0] dsp_result = '0;
    logic [4:0]  dsp_flags = '0;
    logic        dsp_ready = 1'b1;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic        rsp_timeout;
    logic        busy;

    always #5 clk = ~clk;

    fpdsp_issue_ctrl #(.DEPTH(4), .TAG_W(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .dsp_run(dsp_run), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_operation(dsp_operation),
        .dsp_result(dsp_result), .dsp_flags(dsp_flags), .dsp_ready(dsp_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        logic [4:0]  fl;
        int          fall;
        int          lat;
    } mcmd_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        logic [3:0]  tag;
        logic        to;
    } exp_t;

    mcmd_t mq[$];
    exp_t  sbq[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_runs = 0;
    int    cyc = 0;
    int    run_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // FP DSP model: samples operands on run, drops ready after 'fall' cycles
    // (0 = never drops), then raises ready with the result after 'lat' cycles.
    mcmd_t m_cur;
    bit    m_busy = 0;
    int    m_fall = 0;
    int    m_lat = 0;
    always @(negedge clk) begin
        if (dsp_run) begin
            n_runs++;
            run_cyc = cyc;
            chk("run_while_busy", 64'(m_busy), 64'd0);
            chk("run_while_rsp_valid", 64'(rsp_valid), 64'd0);
            if (mq.size() == 0) begin
                chk("run_unexpected", 64'(mq.size()), 64'd1);
            end else begin
                m_cur = mq.pop_front();
                chk("dsp_a", 64'(dsp_a), 64'(m_cur.a));
                chk("dsp_b", 64'(dsp_b), 64'(m_cur.b));
                chk("dsp_operation", 64'(dsp_operation), 64'(m_cur.op));
                if (m_cur.fall == 0) begin
                    dsp_result = m_cur.res;
                    dsp_flags  = m_cur.fl;
                end else begin
                    m_busy = 1;
                    m_fall = m_cur.fall;
                    m_lat  = m_cur.lat;
                end
            end
        end else if (m_busy) begin
            if (m_fall > 0) begin
                m_fall--;
                if (m_fall == 0) dsp_ready = 1'b0;
            end else if (m_lat > 1) begin
                m_lat--;
            end else begin
                dsp_result = m_cur.res;
                dsp_flags  = m_cur.fl;
                dsp_ready  = 1'b1;
                m_busy     = 0;
            end
        end
    end

    // Response monitor: stability while stalled, scoreboard compare on handshake.
    logic [41:0] snap;
    bit          held = 0;
    exp_t        e_mon;
    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else if (rsp_valid) begin
            if (!held) begin
                snap = {rsp_result, rsp_flags, rsp_tag, rsp_timeout};
                held = 1;
            end else begin
                chk("rsp_stable", 64'({rsp_result, rsp_flags, rsp_tag, rsp_timeout}), 64'(snap));
            end
            if (rsp_ready) begin
                held = 0;
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 64'(sbq.size()), 64'd1);
                end else begin
                    e_mon = sbq.pop_front();
                    $display("rsp tag=%0d result=%h flags=%b timeout=%0b",
                             rsp_tag, rsp_result, rsp_flags, rsp_timeout);
                    chk("rsp_result", 64'(rsp_result), 64'(e_mon.res));
                    chk("rsp_flags", 64'(rsp_flags), 64'(e_mon.fl));
                    chk("rsp_tag", 64'(rsp_tag), 64'(e_mon.tag));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e_mon.to));
                end
            end
        end
    end

    // Push one command (called at posedge+1); expectations queued on acceptance.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [3:0] tag, input logic [31:0] res, input logic [4:0] fl,
                        input int fall, input int lat, input bit to);
        int    n = 0;
        mcmd_t m;
        exp_t  e;
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        while (!cmd_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("push_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        $display("cmd tag=%0d a=%h b=%h op=%0d", tag, a, b, op);
        m.a = a; m.b = b; m.op = op; m.res = res; m.fl = fl; m.fall = fall; m.lat = lat;
        mq.push_back(m);
        e.tag = tag;
        e.to  = to;
        e.res = to ? 32'h7FC0_0000 : res;
        e.fl  = to ? 5'b10000 : fl;
        sbq.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_sb_empty"}, 64'(sbq.size()), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outs(input string nm);
        chk({nm, "_dsp_run"}, 64'(dsp_run), 64'd0);
        chk({nm, "_dsp_ab"}, {dsp_a, dsp_b}, 64'd0);
        chk({nm, "_dsp_op"}, 64'(dsp_operation), 64'd0);
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, "_rsp_data"}, 64'({rsp_result, rsp_flags, rsp_tag, rsp_timeout}), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    logic [31:0] t2_a [5] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
    logic [31:0] t2_b [5] = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4040_0000};
    logic [31:0] t2_r [5] = '{32'h4040_0000, 32'h4000_0000, 32'h4100_0000, 32'h4020_0000, 32'h4110_0000};

    initial begin
        int r0;
        int hs;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single add
        r0 = n_runs;
        push(32'h3F80_0000, 32'h4000_0000, 2'b00, 4'd3, 32'h4040_0000, 5'b00000, 1, 8, 1'b0);
        wait_idle("t1");
        chk("t1_run_count", 64'(n_runs - r0), 64'd1);

        // 2: back-to-back fill, 5 commands into a 4-deep FIFO with one in flight
        r0 = n_runs;
        for (int i = 0; i < 5; i++) begin
            push(t2_a[i], t2_b[i], 2'(i), 4'(i), t2_r[i], 5'(i), 1, 8, 1'b0);
        end
        chk("t2_cmd_ready_full", 64'(cmd_ready), 64'd0);
        chk("t2_busy", 64'(busy), 64'd1);
        wait_idle("t2");
        chk("t2_run_count", 64'(n_runs - r0), 64'd5);

        // 3: backpressure, second command must wait for handshake + IDLE
        rsp_ready = 1'b0;
        r0 = n_runs;
        push(32'h4100_0000, 32'h4000_0000, 2'b10, 4'd6, 32'h4180_0000, 5'b00001, 2, 3, 1'b0);
        push(32'h4100_0000, 32'h4000_0000, 2'b11, 4'd7, 32'h4080_0000, 5'b00000, 1, 4, 1'b0);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_no_run_in_hold", 64'(n_runs - r0), 64'd1);
        rsp_ready = 1'b1;
        hs = cyc;
        n = 0;
        while ((n_runs - r0) < 2 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("t3_run_gap", 64'(run_cyc - hs), 64'd2);
        wait_idle("t3");

        // 4: divide by zero, values passed through unchanged
        push(32'h3F80_0000, 32'h0000_0000, 2'b11, 4'd9, 32'h7F80_0000, 5'b01000, 1, 5, 1'b0);
        wait_idle("t4");

        // ready never drops: immediate completion after two WAIT_BUSY cycles
        push(32'h3F80_0000, 32'h3F80_0000, 2'b10, 4'd10, 32'h1234_5678, 5'b00001, 0, 0, 1'b0);
        wait_idle("t_imm");

        // 5: reset mid-operation with two commands queued
        for (int i = 0; i < 3; i++) begin
            push(32'h4000_0000, 32'h4000_0000, 2'b00, 4'(11 + i), 32'h4080_0000, 5'b00000, 1, 20, 1'b0);
        end
        n = 0;
        while (dsp_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("t5_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outs("t5_reset");
        rst = 1'b0;
        mq.delete();
        sbq.delete();
        repeat (40) @(posedge clk);
        #1;
        wait_idle("t5");

`ifdef FPDSP_ISSUE_TIMEOUT_EN
        // 6: model takes far longer than TIMEOUT_CYC; next issue waits for ready
        r0 = n_runs;
        push(32'h3F80_0000, 32'h4000_0000, 2'b01, 4'd14, 32'h1111_1111, 5'b00000, 1, 40, 1'b1);
        push(32'h3F80_0000, 32'h4000_0000, 2'b00, 4'd15, 32'h4040_0000, 5'b00000, 1, 3, 1'b0);
        wait_idle("t6");
        chk("t6_run_count", 64'(n_runs - r0), 64'd2);
`endif

        chk("final_mq_empty", 64'(mq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
